// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    // Controller side
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    // Subtractor side
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );

endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// One-bit half subtractor: diff = a - b without borrow in.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);

    // Pure combinational cell
    always_comb begin
        diff   = a ^ b;
        borrow = ~a & b;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional signed overflow flag enabled by macro SERIAL_SUB_SIGNED_OVF_EN; when undefined the
// overflow output is tied low.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_subtractor_if.slave bus
);

    localparam int unsigned CNT_W = clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             br_q;
    logic             borrow_q;

    logic             hs0_diff;
    logic             hs0_borrow;
    logic             hs1_borrow;
    logic             bit_diff;
    logic             bit_borrow;
    logic             last_bit;

    // Full-subtract cell: two half subtractors plus an OR of their borrows
    half_subtractor u_hs0 (
        .a      (a_sh_q[0]),
        .b      (b_sh_q[0]),
        .diff   (hs0_diff),
        .borrow (hs0_borrow)
    );

    half_subtractor u_hs1 (
        .a      (hs0_diff),
        .b      (br_q),
        .diff   (bit_diff),
        .borrow (hs1_borrow)
    );

    assign bit_borrow = hs0_borrow | hs1_borrow;
    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Operand capture, serial shifting and result commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh_q <= bus.a;
                        b_sh_q <= bus.b;
                        br_q   <= 1'b0;
                        cnt_q  <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
                    sr_q   <= {bit_diff, sr_q[WIDTH-1:1]};
                    br_q   <= bit_borrow;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // The bit computed on the last edge is the MSB of the result
                    if (last_bit) begin
                        diff_q   <= {bit_diff, sr_q[WIDTH-1:1]};
                        borrow_q <= bit_borrow;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    // Capture operand sign bits at start; derive signed overflow at commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && bus.start) begin
                a_msb_q <= bus.a[WIDTH-1];
                b_msb_q <= bus.b[WIDTH-1];
            end
            if (state_q == ST_SHIFT && last_bit) begin
                ovf_q <= (a_msb_q != b_msb_q) && (bit_diff != a_msb_q);
            end
        end
    end
`endif

    // Output drive
    always_comb begin
        bus.busy       = (state_q != ST_IDLE);
        bus.done       = (state_q == ST_DONE);
        bus.diff       = diff_q;
        bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        bus.overflow   = ovf_q;
`else
        bus.overflow   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance for directed and handshake
// scenarios, a 4-bit instance for an exhaustive sweep. Expected results are queued at stimulus
// time and compared when done pulses.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } exp8_t;

    typedef struct packed {
        logic [3:0] diff;
        logic       borrow;
        logic       ovf;
    } exp4_t;

    logic clk;
    logic rst_n;

    int unsigned checks;
    int unsigned errors;

    exp8_t q8[$];
    exp4_t q4[$];

    logic [7:0] held_diff8;
    logic       held_br8;
    logic       done8_prev;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b);
        exp8_t e;
        e.diff   = a - b;
        e.borrow = (a < b);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        e.ovf    = (a[7] != b[7]) && (e.diff[7] != a[7]);
`else
        e.ovf    = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp4_t model4(input logic [3:0] a, input logic [3:0] b);
        exp4_t e;
        e.diff   = a - b;
        e.borrow = (a < b);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        e.ovf    = (a[3] != b[3]) && (e.diff[3] != a[3]);
`else
        e.ovf    = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard for the 8-bit instance: pops on done, checks pulse width and result hold
    initial begin
        done8_prev = 1'b0;
        held_diff8 = '0;
        held_br8   = 1'b0;
        forever begin
            exp8_t e;
            @(negedge clk);
            if (!rst_n) begin
                done8_prev = 1'b0;
                held_diff8 = '0;
                held_br8   = 1'b0;
            end else begin
                if (bus8.done) begin
                    check("done8_single_cycle", {31'b0, done8_prev}, 32'd0);
                    check("done8_expected", {31'b0, q8.size() != 0}, 32'd1);
                    if (q8.size() != 0) begin
                        e = q8.pop_front();
                        check("diff8", {24'b0, bus8.diff}, {24'b0, e.diff});
                        check("borrow8", {31'b0, bus8.borrow_out}, {31'b0, e.borrow});
                        check("overflow8", {31'b0, bus8.overflow}, {31'b0, e.ovf});
                        held_diff8 = e.diff;
                        held_br8   = e.borrow;
                    end
                end else begin
                    check("diff8_held", {24'b0, bus8.diff}, {24'b0, held_diff8});
                    check("borrow8_held", {31'b0, bus8.borrow_out}, {31'b0, held_br8});
                end
                done8_prev = bus8.done;
            end
        end
    end

    // Scoreboard for the 4-bit instance
    initial begin
        forever begin
            exp4_t e;
            @(negedge clk);
            if (rst_n && bus4.done) begin
                check("done4_expected", {31'b0, q4.size() != 0}, 32'd1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    check("diff4", {28'b0, bus4.diff}, {28'b0, e.diff});
                    check("borrow4", {31'b0, bus4.borrow_out}, {31'b0, e.borrow});
                    check("overflow4", {31'b0, bus4.overflow}, {31'b0, e.ovf});
                end
            end
        end
    end

    // One 8-bit operation with latency check; waits for idle first
    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        n = 0;
        while (bus8.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        q8.push_back(model8(a, b));
        @(posedge clk);
        #1 bus8.start = 1'b0;
        n = 0;
        while (!bus8.done && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency8", n, 32'd8);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        int n;
        @(negedge clk);
        n = 0;
        while (bus4.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus4.a     = a;
        bus4.b     = b;
        bus4.start = 1'b1;
        q4.push_back(model4(a, b));
        @(posedge clk);
        #1 bus4.start = 1'b0;
        n = 0;
        while (!bus4.done && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency4", n, 32'd4);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus8.busy}, 32'd0);
        check("rst_done", {31'b0, bus8.done}, 32'd0);
        check("rst_diff", {24'b0, bus8.diff}, 32'd0);
        check("rst_borrow", {31'b0, bus8.borrow_out}, 32'd0);
        check("rst_overflow", {31'b0, bus8.overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations and boundaries
        op8(8'd200, 8'd55);
        op8(8'd5, 8'd9);
        op8(8'h3C, 8'h3C);
        op8(8'h00, 8'hFF);
        op8(8'h80, 8'h01);
        op8(8'h05, 8'h03);
        op8(8'h7F, 8'hFF);

        // Start held high, operands scrambled every cycle; accepts land every WIDTH+2 cycles
        @(negedge clk);
        n = 0;
        while (bus8.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus8.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            if (i % 10 == 0) q8.push_back(model8(bus8.a, bus8.b));
            @(negedge clk);
        end
        bus8.start = 1'b0;
        n = 0;
        while (q8.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("held_start_drain", q8.size(), 32'd0);

        // Reset in the middle of shifting
        op8(8'd200, 8'd55);
        @(negedge clk);
        n = 0;
        while (bus8.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus8.a     = 8'hF0;
        bus8.b     = 8'h0F;
        bus8.start = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus8.busy}, 32'd0);
        check("abort_done", {31'b0, bus8.done}, 32'd0);
        check("abort_diff", {24'b0, bus8.diff}, 32'd0);
        check("abort_borrow", {31'b0, bus8.borrow_out}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", {31'b0, bus8.done}, 32'd0);
        op8(8'h33, 8'h11);

        // Exhaustive 4-bit sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(4'(a), 4'(b));
            end
        end

        repeat (4) @(negedge clk);
        check("q8_empty", q8.size(), 32'd0);
        check("q4_empty", q4.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
